// File: rtl/game_timer_pkg.sv
// Shared types and constants for the period countdown clock.
package game_timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_FIVE = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [DIGIT_W-1:0] BCD_ONE  = 4'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [DIGIT_W-1:0] tens_of(input int value);
    return DIGIT_W'(value / 10);
  endfunction

  function automatic logic [DIGIT_W-1:0] ones_of(input int value);
    return DIGIT_W'(value % 10);
  endfunction

endpackage

// File: rtl/game_timer_bcd_digit_down.sv
// One BCD down-counting digit with a programmable wrap value; borrow_out
// fires in the cycle this digit wraps, enabling the next digit up.
module bcd_digit_down
  import game_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] RESET_VAL = 4'd0
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] q_r;

  // Digit register: load has priority over counting.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= RESET_VAL;
    end else if (load) begin
      q_r <= load_val;
    end else if (en) begin
      q_r <= (q_r == BCD_ZERO) ? max_val : (q_r - 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

  assign borrow_out = en & (q_r == BCD_ZERO);
  assign q          = q_r;

endmodule

// File: rtl/game_timer.sv
// MM:SS period countdown clock: tick edge detect, 1 Hz prescaler, run/pause FSM.
// Optional expiry horn enabled by defining GAME_TIMER_BUZZER_EN.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1562500,
  parameter int PRESCALE_W    = 21,
  parameter int PERIOD_MIN    = 10,
  parameter int PERIOD_SEC    = 0
`ifdef GAME_TIMER_BUZZER_EN
  , parameter int BUZZ_SEC    = 3
`endif
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               tick_src,
  input  logic               start_stop,
  input  logic               load,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               expired,
  output logic               sec_pulse
`ifdef GAME_TIMER_BUZZER_EN
  , output logic             buzzer
`endif
);

  localparam logic [DIGIT_W-1:0]    LD_MT    = tens_of(PERIOD_MIN);
  localparam logic [DIGIT_W-1:0]    LD_MO    = ones_of(PERIOD_MIN);
  localparam logic [DIGIT_W-1:0]    LD_ST    = tens_of(PERIOD_SEC);
  localparam logic [DIGIT_W-1:0]    LD_SO    = ones_of(PERIOD_SEC);
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  state_t                state_r, state_nxt_s;
  logic                  tick_q_r, tick_en_s;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  sec_pulse_r, running_r, expired_r;
  logic                  pre_adv_s, wrap_s, dec_s, last_s, zero_s, one_left_s;
  logic                  b0_s, b1_s, b2_s, b3_s;
  logic [DIGIT_W-1:0]    mt_s, mo_s, st_s, so_s;

  assign tick_en_s  = tick_src & ~tick_q_r;
  assign dec_s      = sec_pulse_r & ~load;
  assign zero_s     = (mt_s == BCD_ZERO) && (mo_s == BCD_ZERO) && (st_s == BCD_ZERO) && (so_s == BCD_ZERO);
  assign one_left_s = (mt_s == BCD_ZERO) && (mo_s == BCD_ZERO) && (st_s == BCD_ZERO) && (so_s == BCD_ONE);
  // A borrow out of the top digit can only mean underflow; treat it as expiry.
  assign last_s     = (dec_s & one_left_s) | b3_s;
  assign wrap_s     = pre_adv_s && (prescale_r == PRE_LAST);

`ifdef GAME_TIMER_BUZZER_EN
  localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_SEC - 1);
  logic       buzzer_r;
  logic [7:0] buzz_cnt_r;

  assign pre_adv_s = tick_en_s & ((state_r == RUN) | ((state_r == DONE) & buzzer_r));

  // Horn: raised on entry to DONE, dropped after BUZZ_SEC prescaler wraps.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      buzzer_r   <= 1'b0;
      buzz_cnt_r <= 8'd0;
    end else if (load) begin
      buzzer_r   <= 1'b0;
      buzz_cnt_r <= 8'd0;
    end else if ((state_nxt_s == DONE) && (state_r != DONE)) begin
      buzzer_r   <= 1'b1;
      buzz_cnt_r <= 8'd0;
    end else if (buzzer_r && wrap_s) begin
      buzzer_r   <= (buzz_cnt_r != BUZZ_LAST);
      buzz_cnt_r <= buzz_cnt_r + 8'd1;
    end else begin
      buzzer_r   <= buzzer_r;
      buzz_cnt_r <= buzz_cnt_r;
    end
  end

  assign buzzer = buzzer_r;
`else
  assign pre_adv_s = tick_en_s & (state_r == RUN);
`endif

  // Rising-edge detector on the divider bit.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_q_r <= 1'b0;
    end else begin
      tick_q_r <= tick_src;
    end
  end

  // Prescaler; holds its partial count while paused so no time is lost.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      prescale_r  <= '0;
      sec_pulse_r <= 1'b0;
    end else if (load) begin
      prescale_r  <= '0;
      sec_pulse_r <= 1'b0;
    end else if (wrap_s) begin
      prescale_r  <= '0;
      sec_pulse_r <= (state_r == RUN);
    end else if (pre_adv_s) begin
      prescale_r  <= prescale_r + PRESCALE_W'(1);
      sec_pulse_r <= 1'b0;
    end else begin
      prescale_r  <= prescale_r;
      sec_pulse_r <= 1'b0;
    end
  end

  // Next-state logic: load beats expiry, expiry beats start_stop.
  always_comb begin
    state_nxt_s = state_r;
    if (load) begin
      state_nxt_s = IDLE;
    end else if (last_s) begin
      state_nxt_s = DONE;
    end else if (start_stop) begin
      case (state_r)
        IDLE:    state_nxt_s = zero_s ? IDLE : RUN;
        RUN:     state_nxt_s = PAUSE;
        PAUSE:   state_nxt_s = RUN;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register with status flags decoded alongside it.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == RUN);
      expired_r <= (state_nxt_s == DONE);
    end
  end

  bcd_digit_down #(.RESET_VAL(LD_SO)) u_sec_ones (
    .clock_in(clock_in), .reset_n(reset_n), .en(dec_s), .load(load),
    .load_val(LD_SO), .max_val(BCD_NINE), .q(so_s), .borrow_out(b0_s)
  );
  bcd_digit_down #(.RESET_VAL(LD_ST)) u_sec_tens (
    .clock_in(clock_in), .reset_n(reset_n), .en(b0_s), .load(load),
    .load_val(LD_ST), .max_val(BCD_FIVE), .q(st_s), .borrow_out(b1_s)
  );
  bcd_digit_down #(.RESET_VAL(LD_MO)) u_min_ones (
    .clock_in(clock_in), .reset_n(reset_n), .en(b1_s), .load(load),
    .load_val(LD_MO), .max_val(BCD_NINE), .q(mo_s), .borrow_out(b2_s)
  );
  bcd_digit_down #(.RESET_VAL(LD_MT)) u_min_tens (
    .clock_in(clock_in), .reset_n(reset_n), .en(b2_s), .load(load),
    .load_val(LD_MT), .max_val(BCD_NINE), .q(mt_s), .borrow_out(b3_s)
  );

  assign min_tens  = mt_s;
  assign min_ones  = mo_s;
  assign sec_tens  = st_s;
  assign sec_ones  = so_s;
  assign running   = running_r;
  assign expired   = expired_r;
  assign sec_pulse = sec_pulse_r;

endmodule
